// File: rtl/flappy_pkg.sv
// -----------------------------------------------------------------------------
// flappy_pkg
// Shared constants and helpers for the Flappy game sequencer:
//   - state encoding (ST_INIT / ST_PLAY / ST_CHECK / ST_LOSE)
//   - BCD digit width and a two-digit BCD score type
//   - default tick divisors for a 100 MHz clock and the collision-check timeout
//   - bcd_inc_sat(): saturating two-digit BCD increment (stops at 99)
// -----------------------------------------------------------------------------
package flappy_pkg;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_LOSE  = 2'd3;

    localparam int BCD_W = 4;

    localparam int FLIGHT_DIV_DEFAULT  = 1666666;
    localparam int OBST_DIV_DEFAULT    = 833333;
    localparam int CHK_TIMEOUT_DEFAULT = 64;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd2_t;

    // Packed as {tens, ones}, so ordinary relational compares are numeric.
    function automatic bcd2_t bcd_inc_sat(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.tens == 4'd9 && v.ones == 4'd9) begin
            r = v;
        end else if (v.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running modulo-DIV counter that advances only while en is high and is
// forced to zero by clr. It reports, combinationally, that the counter will sit
// at its terminal count (DIV-1) during the next cycle while arm is high, so the
// parent can register the tick and keep its outputs flop-driven.
// Ports:
//   clk, srst   - clock, synchronous active-high reset
//   clr         - hold counter at 0 (has priority over en)
//   en          - advance counter this cycle
//   arm         - counting will be enabled next cycle (parent's next state)
//   tc_next     - next cycle is a terminal-count cycle with counting enabled
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    input  logic arm,
    output logic tc_next
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TC = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TC) ? '0 : cnt_q + W'(1);
        end
    end

    // A counter frozen at DIV-1 (e.g. across a collision check) still yields
    // its tick on the first cycle counting resumes.
    assign tc_next = arm && (cnt_d == TC);

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// -----------------------------------------------------------------------------
// flappy_game_ctrl
// Game sequencer for the Flappy datapath: INIT/PLAY/CHECK/LOSE state machine,
// flight and obstacle tick enables, flap-request merging, collision-check
// handshake with timeout, and a saturating two-digit BCD score.
// Optional macro HISCORE_EN: adds a best-score register (cleared only by Reset)
// loaded on entry to LOSE; when undefined Best_Tens/Best_Ones are tied to 0.
// Ports:
//   Clk, Reset                 - clock, synchronous active-high reset
//   Start, Ack                 - level controls (leave INIT / leave LOSE)
//   BtnPress                   - synchronized flap button (level)
//   Pass                       - pulse: bird cleared a pipe
//   Chk_Done, Chk_Hit          - collision check result handshake
//   Flight_Tick, Obstacle_Tick - one-cycle enables
//   Flap                       - flap pulse, coincident with Flight_Tick
//   Chk_Req                    - collision check request (level)
//   q_Initial..q_Lose          - one-hot state
//   Score_*, Best_*            - BCD score / best score
// All outputs are driven directly by flops.
// -----------------------------------------------------------------------------
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int FLIGHT_DIV  = FLIGHT_DIV_DEFAULT,
    parameter int OBST_DIV    = OBST_DIV_DEFAULT,
    parameter int CHK_TIMEOUT = CHK_TIMEOUT_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             BtnPress,
    input  logic             Pass,
    input  logic             Chk_Done,
    input  logic             Chk_Hit,
    output logic             Flight_Tick,
    output logic             Obstacle_Tick,
    output logic             Flap,
    output logic             Chk_Req,
    output logic             q_Initial,
    output logic             q_Play,
    output logic             q_Check,
    output logic             q_Lose,
    output logic [BCD_W-1:0] Score_Tens,
    output logic [BCD_W-1:0] Score_Ones,
    output logic [BCD_W-1:0] Best_Tens,
    output logic [BCD_W-1:0] Best_Ones
);

    localparam int CW = (CHK_TIMEOUT > 1) ? $clog2(CHK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CHK_LAST = CW'(CHK_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    onehot_q, onehot_d;
    logic          chk_req_q, chk_req_d;
    logic [CW-1:0] chk_cnt_q, chk_cnt_d;
    logic          flight_tick_q, obst_tick_q;
    logic          flap_q, flap_d;
    logic          pending_q, pending_d;
    logic          btn_prev_q;
    bcd2_t         score_q, score_d;

    logic          flight_tc_next, obst_tc_next;
    logic          in_game, btn_edge, pend_set;
    logic          cnt_clr, cnt_en, cnt_arm;

    // Counters clear in INIT/LOSE, advance in PLAY and freeze in CHECK.
    assign cnt_clr = (state_q == ST_INIT) || (state_q == ST_LOSE);
    assign cnt_en  = (state_q == ST_PLAY);
    assign cnt_arm = (state_d == ST_PLAY);

    tick_gen #(.DIV(FLIGHT_DIV)) u_flight_tick (
        .clk     (Clk),
        .srst    (Reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .arm     (cnt_arm),
        .tc_next (flight_tc_next)
    );

    tick_gen #(.DIV(OBST_DIV)) u_obst_tick (
        .clk     (Clk),
        .srst    (Reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .arm     (cnt_arm),
        .tc_next (obst_tc_next)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (Start) state_d = ST_PLAY;
            ST_PLAY:  if (flight_tick_q) state_d = ST_CHECK;
            ST_CHECK: begin
                // A result arriving on the last allowed cycle still counts.
                if (Chk_Done) begin
                    state_d = Chk_Hit ? ST_LOSE : ST_PLAY;
                end else if (chk_cnt_q == CHK_LAST) begin
                    state_d = ST_LOSE;
                end
            end
            ST_LOSE:  if (Ack) state_d = ST_INIT;
            default:  state_d = ST_INIT;
        endcase
    end

    // ---------------- FSM: outputs (registered from next state) ----------------
    always_comb begin
        onehot_d  = 4'b1000;
        chk_req_d = 1'b0;
        case (state_d)
            ST_INIT:  onehot_d = 4'b1000;
            ST_PLAY:  onehot_d = 4'b0100;
            ST_CHECK: begin
                onehot_d  = 4'b0010;
                chk_req_d = 1'b1;
            end
            ST_LOSE:  onehot_d = 4'b0001;
            default:  onehot_d = 4'b1000;
        endcase
    end

    // ---------------- Datapath: check timer, flap, score ----------------
    always_comb begin
        chk_cnt_d = (state_q == ST_CHECK) ? chk_cnt_q + CW'(1) : '0;

        in_game  = (state_q == ST_PLAY) || (state_q == ST_CHECK);
        btn_edge = in_game && BtnPress && !btn_prev_q;
        pend_set = pending_q || btn_edge;

        // Any number of edges before a flight tick collapse into one flap.
        flap_d    = flight_tc_next && pend_set;
        pending_d = pend_set && !flap_d;
        if (state_d == ST_INIT || state_d == ST_LOSE) begin
            pending_d = 1'b0;
        end

        score_d = score_q;
        if (state_q == ST_INIT && Start) begin
            score_d = '0;
        end else if (in_game && Pass) begin
            score_d = bcd_inc_sat(score_q);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            onehot_q      <= 4'b1000;
            chk_req_q     <= 1'b0;
            chk_cnt_q     <= '0;
            flight_tick_q <= 1'b0;
            obst_tick_q   <= 1'b0;
            flap_q        <= 1'b0;
            pending_q     <= 1'b0;
            btn_prev_q    <= 1'b0;
            score_q       <= '0;
        end else begin
            onehot_q      <= onehot_d;
            chk_req_q     <= chk_req_d;
            chk_cnt_q     <= chk_cnt_d;
            flight_tick_q <= flight_tc_next;
            obst_tick_q   <= obst_tc_next;
            flap_q        <= flap_d;
            pending_q     <= pending_d;
            btn_prev_q    <= BtnPress;
            score_q       <= score_d;
        end
    end

`ifdef HISCORE_EN
    bcd2_t best_q, best_d;

    // score_d already includes a Pass landing on the losing edge.
    always_comb begin
        best_d = best_q;
        if (state_q != ST_LOSE && state_d == ST_LOSE && score_d > best_q) begin
            best_d = score_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            best_q <= '0;
        end else begin
            best_q <= best_d;
        end
    end

    assign Best_Tens = best_q.tens;
    assign Best_Ones = best_q.ones;
`else
    assign Best_Tens = '0;
    assign Best_Ones = '0;
`endif

    assign Flight_Tick   = flight_tick_q;
    assign Obstacle_Tick = obst_tick_q;
    assign Flap          = flap_q;
    assign Chk_Req       = chk_req_q;
    assign q_Initial     = onehot_q[3];
    assign q_Play        = onehot_q[2];
    assign q_Check       = onehot_q[1];
    assign q_Lose        = onehot_q[0];
    assign Score_Tens    = score_q.tens;
    assign Score_Ones    = score_q.ones;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flappy_game_ctrl
// Self-checking bench for flappy_game_ctrl with FLIGHT_DIV=4, OBST_DIV=6,
// CHK_TIMEOUT=8. Expected values are queued when stimulus is applied and
// popped when the corresponding DUT output is sampled (1 time unit after the
// clock edge). Best-score expectations follow the HISCORE_EN macro.
// -----------------------------------------------------------------------------
module tb_flappy_game_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0, Ack = 1'b0, BtnPress = 1'b0, Pass = 1'b0;
    logic       Chk_Done = 1'b0, Chk_Hit = 1'b0;
    logic       Flight_Tick, Obstacle_Tick, Flap, Chk_Req;
    logic       q_Initial, q_Play, q_Check, q_Lose;
    logic [3:0] Score_Tens, Score_Ones, Best_Tens, Best_Ones;

    int checks = 0;
    int errors = 0;
    bit auto_resp = 1'b0;

    logic [7:0] exp_obs_q[$];
    logic [7:0] exp_score_q[$];
    logic       exp_flap_q[$];
    int         exp_cnt_q[$];

    // Observation word: {Initial, Play, Check, Lose, FTick, OTick, Flap, ChkReq}
    localparam logic [7:0] O_INIT  = 8'h80;
    localparam logic [7:0] O_PLAY  = 8'h40;
    localparam logic [7:0] O_CHECK = 8'h21;
    localparam logic [7:0] O_LOSE  = 8'h10;
    localparam logic [7:0] B_FT    = 8'h08;
    localparam logic [7:0] B_OT    = 8'h04;

`ifdef HISCORE_EN
    localparam logic [7:0] EXP_BEST = 8'h05;
`else
    localparam logic [7:0] EXP_BEST = 8'h00;
`endif

    flappy_game_ctrl #(
        .FLIGHT_DIV  (4),
        .OBST_DIV    (6),
        .CHK_TIMEOUT (8)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .Ack           (Ack),
        .BtnPress      (BtnPress),
        .Pass          (Pass),
        .Chk_Done      (Chk_Done),
        .Chk_Hit       (Chk_Hit),
        .Flight_Tick   (Flight_Tick),
        .Obstacle_Tick (Obstacle_Tick),
        .Flap          (Flap),
        .Chk_Req       (Chk_Req),
        .q_Initial     (q_Initial),
        .q_Play        (q_Play),
        .q_Check       (q_Check),
        .q_Lose        (q_Lose),
        .Score_Tens    (Score_Tens),
        .Score_Ones    (Score_Ones),
        .Best_Tens     (Best_Tens),
        .Best_Ones     (Best_Ones)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] obs();
        return {q_Initial, q_Play, q_Check, q_Lose, Flight_Tick, Obstacle_Tick, Flap, Chk_Req};
    endfunction

    function automatic logic [7:0] bcd(input int n);
        int v;
        v = (n > 99) ? 99 : n;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Advance one clock; optional automatic "no hit" responder for checks.
    task automatic step();
        @(posedge Clk);
        #1;
        if (auto_resp) begin
            Chk_Hit  = 1'b0;
            Chk_Done = Chk_Req;
        end
    endtask

    task automatic wait_flight_tick(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (Flight_Tick) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s flight_tick_timeout got=none exp=tick", tag);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        checks++;
        if (obs() !== O_INIT) begin
            errors++;
            $display("FAIL reset_obs got=%h exp=%h", obs(), O_INIT);
        end else $display("ok   reset_obs got=%h", obs());
        checks++;
        if ({Score_Tens, Score_Ones} !== 8'h00) begin
            errors++;
            $display("FAIL reset_score got=%h exp=00", {Score_Tens, Score_Ones});
        end else $display("ok   reset_score got=00");
        checks++;
        if ({Best_Tens, Best_Ones} !== 8'h00) begin
            errors++;
            $display("FAIL reset_best got=%h exp=00", {Best_Tens, Best_Ones});
        end else $display("ok   reset_best got=00");
        Reset = 1'b0;
    endtask

    // Start -> PLAY next cycle, first flight tick on 4th PLAY cycle, CHECK after.
    task automatic test_start_tick();
        logic [7:0] e;
        exp_obs_q.push_back(O_PLAY);
        exp_obs_q.push_back(O_PLAY);
        exp_obs_q.push_back(O_PLAY);
        exp_obs_q.push_back(O_PLAY | B_FT);
        exp_obs_q.push_back(O_CHECK);
        Start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            Start = 1'b0;
            e = exp_obs_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL start_seq[%0d] got=%h exp=%h", i, obs(), e);
            end else $display("ok   start_seq[%0d] got=%h", i, obs());
        end
    endtask

    // Done/no-hit after 3 CHECK cycles; counters resume from frozen values.
    task automatic test_check_resume();
        logic [7:0] e;
        exp_obs_q.push_back(O_CHECK);
        exp_obs_q.push_back(O_CHECK);
        exp_obs_q.push_back(O_PLAY);
        exp_obs_q.push_back(O_PLAY | B_OT);
        exp_obs_q.push_back(O_PLAY);
        exp_obs_q.push_back(O_PLAY | B_FT);
        exp_obs_q.push_back(O_CHECK);
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 1) begin
                Chk_Done = 1'b1;
                Chk_Hit  = 1'b0;
            end else begin
                Chk_Done = 1'b0;
            end
            e = exp_obs_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL resume_seq[%0d] got=%h exp=%h", i, obs(), e);
            end else $display("ok   resume_seq[%0d] got=%h", i, obs());
        end
    endtask

    // Entered on the first CHECK cycle. Three button edges -> one Flap.
    task automatic test_flap();
        logic [7:0] e;
        logic       ef;
        int         stray;
        for (int i = 0; i < 5; i++) exp_obs_q.push_back(O_CHECK);
        exp_obs_q.push_back(O_PLAY);
        for (int i = 0; i < 6; i++) begin
            BtnPress = (i % 2 == 0);
            if (i == 5) begin
                Chk_Done = 1'b1;
                Chk_Hit  = 1'b0;
            end
            step();
            e = exp_obs_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL flap_btn[%0d] got=%h exp=%h", i, obs(), e);
            end else $display("ok   flap_btn[%0d] got=%h", i, obs());
        end
        BtnPress = 1'b0;
        Chk_Done = 1'b0;
        auto_resp = 1'b1;
        exp_flap_q.push_back(1'b1);
        exp_flap_q.push_back(1'b0);
        stray = 0;
        for (int t = 0; t < 2; t++) begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 50 && !found; i++) begin
                step();
                if (Flight_Tick) found = 1'b1;
                else if (Flap) stray++;
            end
            ef = exp_flap_q.pop_front();
            checks++;
            if (!found || Flap !== ef) begin
                errors++;
                $display("FAIL flap_at_tick[%0d] got=%b tick=%b exp=%b", t, Flap, found, ef);
            end else $display("ok   flap_at_tick[%0d] got=%b", t, Flap);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL flap_stray got=%0d exp=0", stray);
        end else $display("ok   flap_stray got=0");
    endtask

    // Obstacle tick period counts only PLAY cycles (CHECK cycles frozen).
    task automatic test_obstacle_spacing();
        bit found;
        int e;
        auto_resp = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (Obstacle_Tick) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL obst_first got=none exp=tick");
        end
        for (int k = 0; k < 3; k++) begin
            int cnt;
            exp_cnt_q.push_back(6);
            cnt = 0;
            found = 1'b0;
            for (int i = 0; i < 100 && !found; i++) begin
                step();
                if (q_Play) cnt++;
                if (Obstacle_Tick) found = 1'b1;
            end
            e = exp_cnt_q.pop_front();
            checks++;
            if (!found || cnt !== e) begin
                errors++;
                $display("FAIL obst_spacing[%0d] got=%0d exp=%0d", k, cnt, e);
            end else $display("ok   obst_spacing[%0d] got=%0d", k, cnt);
        end
    endtask

    // 101 Pass pulses while playing: 09->10 carry and saturation at 99.
    task automatic test_score();
        logic [7:0] e;
        auto_resp = 1'b1;
        for (int n = 1; n <= 101; n++) begin
            Pass = 1'b1;
            exp_score_q.push_back(bcd(n));
            step();
            Pass = 1'b0;
            e = exp_score_q.pop_front();
            checks++;
            if ({Score_Tens, Score_Ones} !== e) begin
                errors++;
                $display("FAIL score_pass[%0d] got=%h exp=%h", n, {Score_Tens, Score_Ones}, e);
            end else $display("ok   score_pass[%0d] got=%h", n, {Score_Tens, Score_Ones});
            step();
        end
    endtask

    // Withheld Chk_Done -> LOSE after 8 CHECK cycles; Start/Ack/Pass gating.
    task automatic test_timeout_lose();
        logic [7:0] e;
        auto_resp = 1'b1;
        wait_flight_tick("timeout");
        auto_resp = 1'b0;
        Chk_Done  = 1'b0;
        for (int i = 0; i < 8; i++) exp_obs_q.push_back(O_CHECK);
        exp_obs_q.push_back(O_LOSE);
        for (int i = 0; i < 9; i++) begin
            step();
            e = exp_obs_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL timeout_seq[%0d] got=%h exp=%h", i, obs(), e);
            end else $display("ok   timeout_seq[%0d] got=%h", i, obs());
        end
        Start = 1'b1;
        step();
        Start = 1'b0;
        checks++;
        if (obs() !== O_LOSE) begin
            errors++;
            $display("FAIL start_in_lose got=%h exp=%h", obs(), O_LOSE);
        end else $display("ok   start_in_lose got=%h", obs());
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        checks++;
        if (obs() !== O_INIT || {Score_Tens, Score_Ones} !== 8'h99) begin
            errors++;
            $display("FAIL ack_to_init got=%h score=%h exp=%h score=99", obs(), {Score_Tens, Score_Ones}, O_INIT);
        end else $display("ok   ack_to_init got=%h score=99", obs());
        Start = 1'b1;
        step();
        Start = 1'b0;
        checks++;
        if (obs() !== O_PLAY || {Score_Tens, Score_Ones} !== 8'h00) begin
            errors++;
            $display("FAIL restart_clear got=%h score=%h exp=%h score=00", obs(), {Score_Tens, Score_Ones}, O_PLAY);
        end else $display("ok   restart_clear got=%h score=00", obs());
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        checks++;
        if (q_Play !== 1'b1) begin
            errors++;
            $display("FAIL ack_in_play got=%b exp=1", q_Play);
        end else $display("ok   ack_in_play got=1");
    endtask

    // One game ending by a hit with a Pass on the losing edge.
    task automatic play_game(input int final_score, input string tag);
        logic [7:0] e;
        Start = 1'b1;
        step();
        Start = 1'b0;
        auto_resp = 1'b1;
        for (int i = 1; i < final_score; i++) begin
            Pass = 1'b1;
            step();
            Pass = 1'b0;
            step();
        end
        wait_flight_tick(tag);
        auto_resp = 1'b0;
        Chk_Done  = 1'b0;
        step();
        Pass     = 1'b1;
        Chk_Done = 1'b1;
        Chk_Hit  = 1'b1;
        exp_score_q.push_back(bcd(final_score));
        step();
        Pass     = 1'b0;
        Chk_Done = 1'b0;
        Chk_Hit  = 1'b0;
        e = exp_score_q.pop_front();
        checks++;
        if (obs() !== O_LOSE || {Score_Tens, Score_Ones} !== e) begin
            errors++;
            $display("FAIL %s_lose got=%h score=%h exp=%h score=%h", tag, obs(), {Score_Tens, Score_Ones}, O_LOSE, e);
        end else $display("ok   %s_lose got=%h score=%h", tag, obs(), e);
        checks++;
        if ({Best_Tens, Best_Ones} !== EXP_BEST) begin
            errors++;
            $display("FAIL %s_best got=%h exp=%h", tag, {Best_Tens, Best_Ones}, EXP_BEST);
        end else $display("ok   %s_best got=%h", tag, EXP_BEST);
        Pass = 1'b1;
        step();
        Pass = 1'b0;
        checks++;
        if ({Score_Tens, Score_Ones} !== e) begin
            errors++;
            $display("FAIL %s_pass_in_lose got=%h exp=%h", tag, {Score_Tens, Score_Ones}, e);
        end else $display("ok   %s_pass_in_lose got=%h", tag, e);
        Ack = 1'b1;
        step();
        Ack  = 1'b0;
        Pass = 1'b1;
        step();
        Pass = 1'b0;
        checks++;
        if (obs() !== O_INIT || {Score_Tens, Score_Ones} !== e) begin
            errors++;
            $display("FAIL %s_pass_in_init got=%h score=%h exp=%h score=%h", tag, obs(), {Score_Tens, Score_Ones}, O_INIT, e);
        end else $display("ok   %s_pass_in_init got=%h score=%h", tag, obs(), e);
    endtask

    task automatic test_hiscore();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        play_game(5, "game1");
        play_game(3, "game2");
        // Reset in the middle of a collision check.
        Start = 1'b1;
        step();
        Start = 1'b0;
        auto_resp = 1'b1;
        wait_flight_tick("midcheck");
        auto_resp = 1'b0;
        Chk_Done  = 1'b0;
        step();
        checks++;
        if (obs() !== O_CHECK) begin
            errors++;
            $display("FAIL midcheck_state got=%h exp=%h", obs(), O_CHECK);
        end else $display("ok   midcheck_state got=%h", obs());
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (obs() !== O_INIT || {Best_Tens, Best_Ones} !== 8'h00 || {Score_Tens, Score_Ones} !== 8'h00) begin
            errors++;
            $display("FAIL midcheck_reset got=%h best=%h score=%h exp=%h best=00 score=00",
                     obs(), {Best_Tens, Best_Ones}, {Score_Tens, Score_Ones}, O_INIT);
        end else $display("ok   midcheck_reset got=%h best=00", obs());
    endtask

    initial begin
        test_reset();
        test_start_tick();
        test_check_resume();
        test_flap();
        test_obstacle_spacing();
        test_score();
        test_timeout_lose();
        test_hiscore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
